// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the Y/Z operand sequencer.
// ST_MUL_RUN exists only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_NEG  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

`ifdef ALU_MUL_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD_Y, ST_EXEC, ST_WRITE_Z, ST_MUL_RUN} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD_Y, ST_EXEC, ST_WRITE_Z} state_t;
`endif

endpackage

// File: rtl/alu_yz_sequencer_booth_mul_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand, then arithmetic shift right.
// Purely combinational; the accumulator is one bit wider so adding/subtracting INT_MIN cannot overflow.
module booth_mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH:0]   hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             q1_i,
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             q1_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  assign m_ext = {m_i[WIDTH-1], m_i};

  always_comb begin
    sum = hi_i;
    case ({lo_i[0], q1_i})
      2'b01:   sum = hi_i + m_ext;
      2'b10:   sum = hi_i - m_ext;
      default: sum = hi_i;
    endcase
  end

  assign hi_o = {sum[WIDTH], sum[WIDTH:1]};
  assign lo_o = {sum[0], lo_i[WIDTH-1:1]};
  assign q1_o = lo_i[0];

endmodule

// File: rtl/alu_yz_sequencer.sv
// Stages operand A into Y, applies f(Y, bus) and writes Z; start->done is 3 cycles (35 for MUL).
// start is ignored unless IDLE (no queueing); op 9 multiplies only when ALU_MUL_EN is defined.
module alu_yz_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] bus_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhi,
  output logic [WIDTH-1:0] zlo,
  output logic [WIDTH-1:0] y_out
);

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   zhi_q, zhi_d, zlo_q, zlo_d;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH:0]     add_full, sub_full;
  logic [SHAMT_W-1:0] shamt;

  assign add_full = {1'b0, y_q} + {1'b0, bus_in};
  assign sub_full = {1'b0, y_q} - {1'b0, bus_in};
  assign shamt    = bus_in[SHAMT_W-1:0];

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      OP_OR:   res_lo = y_q | bus_in;
      OP_AND:  res_lo = y_q & bus_in;
      OP_ADD:  begin
        res_lo = add_full[WIDTH-1:0];
        res_hi = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
      end
      OP_SUB:  begin
        res_lo = sub_full[WIDTH-1:0];
        res_hi = {{(WIDTH-1){1'b0}}, sub_full[WIDTH]};
      end
      OP_SHL:  res_lo = y_q << shamt;
      OP_SHR:  res_lo = y_q >> shamt;
      OP_SHRA: res_lo = $signed(y_q) >>> shamt;
      OP_NOT:  res_lo = ~y_q;
      OP_NEG:  res_lo = -y_q;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH:0]   mhi_q, mhi_d, step_hi;
  logic [WIDTH-1:0] mlo_q, mlo_d, step_lo;
  logic             mq1_q, mq1_d, step_q1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  booth_mul_step #(.WIDTH(WIDTH)) u_step (
    .m_i  (y_q),
    .hi_i (mhi_q),
    .lo_i (mlo_q),
    .q1_i (mq1_q),
    .hi_o (step_hi),
    .lo_o (step_lo),
    .q1_o (step_q1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mhi_q <= '0;
      mlo_q <= '0;
      mq1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mhi_q <= mhi_d;
      mlo_q <= mlo_d;
      mq1_q <= mq1_d;
      cnt_q <= cnt_d;
    end
  end
`endif

  // Z is loaded on entry to WRITE_Z so that done and the new Z are visible together.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    y_d     = y_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_WRITE_Z);
`ifdef ALU_MUL_EN
    mhi_d   = mhi_q;
    mlo_d   = mlo_q;
    mq1_d   = mq1_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          state_d = ST_LOAD_Y;
        end
      end
      ST_LOAD_Y: begin
        y_d     = bus_in;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          mhi_d   = '0;
          mlo_d   = bus_in;
          mq1_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_MUL_RUN;
        end else begin
          zhi_d   = res_hi;
          zlo_d   = res_lo;
          state_d = ST_WRITE_Z;
        end
`else
        zhi_d   = res_hi;
        zlo_d   = res_lo;
        state_d = ST_WRITE_Z;
`endif
      end
      ST_WRITE_Z: state_d = ST_IDLE;
`ifdef ALU_MUL_EN
      ST_MUL_RUN: begin
        mhi_d = step_hi;
        mlo_d = step_lo;
        mq1_d = step_q1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          zhi_d   = step_hi[WIDTH-1:0];
          zlo_d   = step_lo;
          state_d = ST_WRITE_Z;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      y_q     <= y_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
    end
  end

  assign zhi   = zhi_q;
  assign zlo   = zlo_q;
  assign y_out = y_q;

endmodule

// File: tb/tb_alu_yz_sequencer.sv
// Directed bench for alu_yz_sequencer: hand-computed vectors per scenario, summary line at the end.
// Expected MUL results depend on whether ALU_MUL_EN is defined for the build.
module tb_alu_yz_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] bus_in;
  logic        busy, done;
  logic [31:0] zhi, zlo, y_out;

  int n_checks = 0;
  int n_pass   = 0;

  alu_yz_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .bus_in (bus_in),
    .busy   (busy),
    .done   (done),
    .zhi    (zhi),
    .zlo    (zlo),
    .y_out  (y_out)
  );

  always #5 clk = ~clk;

  // Drives one op (A held through LOAD_Y, B from EXEC on) for win cycles, sampling on negedges.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int win, input int ign_k,
                        output int lat, output int ndone,
                        output logic [31:0] rhi, output logic [31:0] rlo, output logic bsy1);
    lat = 0; ndone = 0; rhi = '0; rlo = '0; bsy1 = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; bus_in = a;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      start = (k == ign_k);
      if (k == 2) bus_in = b;
      if (k == 1) bsy1 = busy;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = k; rhi = zhi; rlo = zlo;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 4'd0; bus_in = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++; if (zhi !== 32'h0)   $display("FAIL reset_zhi: got %h want 0", zhi);   else n_pass++;
    n_checks++; if (zlo !== 32'h0)   $display("FAIL reset_zlo: got %h want 0", zlo);   else n_pass++;
    n_checks++; if (y_out !== 32'h0) $display("FAIL reset_y: got %h want 0", y_out);   else n_pass++;
    n_checks++; if (busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0)   $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_or();
    int lat, nd; logic [31:0] h, l; logic b1;
    run_op(4'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 8, 0, lat, nd, h, l, b1);
    n_checks++; if (lat !== 3)            $display("FAIL or_lat: got %0d want 3", lat);        else n_pass++;
    n_checks++; if (l !== 32'hFFFF_FFFD)  $display("FAIL or_zlo: got %h want fffffffd", l);    else n_pass++;
    n_checks++; if (h !== 32'h0)          $display("FAIL or_zhi: got %h want 0", h);          else n_pass++;
    n_checks++; if (nd !== 1)             $display("FAIL or_ndone: got %0d want 1", nd);      else n_pass++;
    n_checks++; if (b1 !== 1'b1)          $display("FAIL or_busy: got %b want 1", b1);        else n_pass++;
    n_checks++; if (y_out !== 32'hFFFF_FFFC) $display("FAIL or_y_hold: got %h want fffffffc", y_out); else n_pass++;
    n_checks++; if (busy !== 1'b0)        $display("FAIL or_idle_busy: got %b want 0", busy); else n_pass++;
    run_op(4'd0, 32'h5, 32'hA, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'hF)          $display("FAIL or2_zlo: got %h want f", l);         else n_pass++;
  endtask

  task automatic test_arith_logic();
    int lat, nd; logic [31:0] h, l; logic b1;
    run_op(4'd2, 32'hFFFF_FFFF, 32'h1, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'h0) $display("FAIL add_zlo: got %h want 0", l); else n_pass++;
    n_checks++; if (h !== 32'h1) $display("FAIL add_zhi: got %h want 1", h); else n_pass++;
    run_op(4'd3, 32'h0, 32'h1, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'hFFFF_FFFF) $display("FAIL sub_zlo: got %h want ffffffff", l); else n_pass++;
    n_checks++; if (h !== 32'h1)         $display("FAIL sub_zhi: got %h want 1", h);        else n_pass++;
    run_op(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'hF000_F000) $display("FAIL and_zlo: got %h want f000f000", l); else n_pass++;
    run_op(4'd7, 32'h0000_FFFF, 32'h1234_0000, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'hFFFF_0000) $display("FAIL not_zlo: got %h want ffff0000", l); else n_pass++;
    n_checks++; if (h !== 32'h0)         $display("FAIL not_zhi: got %h want 0", h);        else n_pass++;
    run_op(4'd8, 32'h8000_0000, 32'h0, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'h8000_0000) $display("FAIL neg_min_zlo: got %h want 80000000", l); else n_pass++;
    run_op(4'd8, 32'h1, 32'h0, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'hFFFF_FFFF) $display("FAIL neg1_zlo: got %h want ffffffff", l); else n_pass++;
  endtask

  task automatic test_shift();
    int lat, nd; logic [31:0] h, l; logic b1;
    run_op(4'd6, 32'h8000_0000, 32'h21, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'hC000_0000) $display("FAIL shra_zlo: got %h want c0000000", l); else n_pass++;
    run_op(4'd4, 32'h1234_5678, 32'h20, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'h1234_5678) $display("FAIL shl0_zlo: got %h want 12345678", l); else n_pass++;
    run_op(4'd5, 32'h8000_0000, 32'h1F, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'h1) $display("FAIL shr_zlo: got %h want 1", l); else n_pass++;
    run_op(4'd4, 32'h1, 32'h4, 6, 0, lat, nd, h, l, b1);
    n_checks++; if (l !== 32'h10) $display("FAIL shl4_zlo: got %h want 10", l); else n_pass++;
  endtask

  task automatic test_ignored_illegal();
    int lat, nd; logic [31:0] h, l; logic b1;
    run_op(4'd0, 32'h1, 32'h2, 12, 1, lat, nd, h, l, b1);
    n_checks++; if (nd !== 1)     $display("FAIL ign_load_ndone: got %0d want 1", nd); else n_pass++;
    n_checks++; if (l !== 32'h3)  $display("FAIL ign_load_zlo: got %h want 3", l);     else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ign_load_busy: got %b want 0", busy); else n_pass++;
    run_op(4'd0, 32'h4, 32'h8, 12, 3, lat, nd, h, l, b1);
    n_checks++; if (nd !== 1)     $display("FAIL ign_wz_ndone: got %0d want 1", nd);   else n_pass++;
    run_op(4'hF, 32'hAAAA_AAAA, 32'h5555_5555, 10, 0, lat, nd, h, l, b1);
    n_checks++; if (lat !== 3)    $display("FAIL ill_lat: got %0d want 3", lat);       else n_pass++;
    n_checks++; if (nd !== 1)     $display("FAIL ill_ndone: got %0d want 1", nd);      else n_pass++;
    n_checks++; if (l !== 32'h0)  $display("FAIL ill_zlo: got %h want 0", l);          else n_pass++;
    n_checks++; if (h !== 32'h0)  $display("FAIL ill_zhi: got %h want 0", h);          else n_pass++;
  endtask

  task automatic test_mul();
    int lat, nd; logic [31:0] h, l; logic b1;
    logic [31:0] exp_hi, exp_lo; int exp_lat;
`ifdef ALU_MUL_EN
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF9; exp_lat = 35;
`else
    exp_hi = 32'h0; exp_lo = 32'h0; exp_lat = 3;
`endif
    run_op(4'd2, 32'hFFFF_FFFF, 32'h1, 6, 0, lat, nd, h, l, b1);
    run_op(4'd9, 32'hFFFF_FFFF, 32'h7, 45, 0, lat, nd, h, l, b1);
    n_checks++; if (lat !== exp_lat) $display("FAIL mul_lat: got %0d want %0d", lat, exp_lat); else n_pass++;
    n_checks++; if (nd !== 1)        $display("FAIL mul_ndone: got %0d want 1", nd);          else n_pass++;
    n_checks++; if (h !== exp_hi)    $display("FAIL mul_zhi: got %h want %h", h, exp_hi);     else n_pass++;
    n_checks++; if (l !== exp_lo)    $display("FAIL mul_zlo: got %h want %h", l, exp_lo);     else n_pass++;
`ifdef ALU_MUL_EN
    run_op(4'd9, 32'h8000_0000, 32'h8000_0000, 45, 0, lat, nd, h, l, b1);
    n_checks++; if ({h, l} !== 64'h4000_0000_0000_0000) $display("FAIL mul_min_sq: got %h%h want 4000000000000000", h, l); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_op();
    int lat, nd; logic [31:0] h, l; logic b1;
    run_op(4'd2, 32'hFFFF_FFFF, 32'h1, 6, 0, lat, nd, h, l, b1);
    @(negedge clk); start = 1'b1; op = 4'd0; bus_in = 32'h0000_1234;
    @(negedge clk); start = 1'b0;
    @(negedge clk); bus_in = 32'h0000_4321;
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (zhi !== 32'h0)   $display("FAIL rmid_zhi: got %h want 0", zhi);   else n_pass++;
    n_checks++; if (zlo !== 32'h0)   $display("FAIL rmid_zlo: got %h want 0", zlo);   else n_pass++;
    n_checks++; if (y_out !== 32'h0) $display("FAIL rmid_y: got %h want 0", y_out);   else n_pass++;
    n_checks++; if (busy !== 1'b0)   $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    rst_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_checks++; if (nd !== 0)      $display("FAIL rmid_no_done: got %0d want 0", nd); else n_pass++;
    n_checks++; if (zlo !== 32'h0) $display("FAIL rmid_z_kept: got %h want 0", zlo);  else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, nd; logic [31:0] h, l; logic b1;
    run_op(4'd0, 32'h5, 32'hA, 3, 0, lat, nd, h, l, b1);
    n_checks++; if (lat !== 3 || l !== 32'hF) $display("FAIL b2b_1: got lat %0d zlo %h want 3 f", lat, l); else n_pass++;
    run_op(4'd2, 32'h2, 32'h3, 3, 0, lat, nd, h, l, b1);
    n_checks++; if (lat !== 3 || l !== 32'h5) $display("FAIL b2b_2: got lat %0d zlo %h want 3 5", lat, l); else n_pass++;
    run_op(4'd3, 32'h5, 32'h7, 3, 0, lat, nd, h, l, b1);
    n_checks++; if (lat !== 3 || l !== 32'hFFFF_FFFE || h !== 32'h1)
      $display("FAIL b2b_3: got lat %0d z %h_%h want 3 00000001_fffffffe", lat, h, l); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_or();
    test_arith_logic();
    test_shift();
    test_ignored_illegal();
    test_mul();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
